// File: rtl/kerbin_addr_decoder.sv
// ---------------------------------------------------------------------------
// kerbin_addr_decoder
//
// Runtime-programmable, pipelined address decoder for the Kerbin SoC
// interconnect. It sits in front of the crossbar AW/AR demux and maps each
// request address onto a slave index.
//
// The block holds NR_RULES address windows [start, end). Each window resets
// to its parameter value, and software may rewrite it until the table is
// locked. An address that matches no window is reported as a miss and is
// routed to the error slave, whose index is NR_RULES.
//
// The decoder performs one lookup per cycle. The result goes through a
// single output register, so the latency is one cycle.
//
// Parameters
//   NR_RULES    number of address windows (>= 1)
//   ADDR_WIDTH  address width
//   START_ADDR  reset start address of each rule,
//               packed [NR_RULES-1:0][ADDR_WIDTH-1:0]
//   END_ADDR    reset end address (exclusive) of each rule, same shape
//   IDX_WIDTH   width of the slave index (derived; do not override)
//
// Ports
//   clk_i         clock; all logic runs on the rising edge
//   rst_ni        asynchronous active-low reset
//   cfg_we_i      single-cycle config write strobe
//   cfg_idx_i     rule to write
//   cfg_sel_i     0: write the start address, 1: write the end address
//   cfg_data_i    value to write
//   cfg_lock_i    sets the lock; the table is read-only until reset
//   cfg_err_o     1-cycle pulse when a write is rejected
//                 (table locked or index out of range)
//   cfg_locked_o  current lock state
//   req_valid_i   lookup request is valid
//   req_ready_o   decoder can accept a request
//   req_addr_i    address to decode
//   rsp_valid_o   lookup result is valid
//   rsp_ready_i   consumer accepts the result
//   rsp_idx_o     matched rule index, or NR_RULES on a miss
//   rsp_miss_o    no rule matched
//   miss_cnt_o    saturating count of accepted lookups that missed
// ---------------------------------------------------------------------------
module kerbin_addr_decoder #(
    parameter int NR_RULES   = 3,
    parameter int ADDR_WIDTH = 64,
    parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] START_ADDR =
        {64'h0, 64'h8000_0000, 64'h1A00_0000},
    parameter logic [NR_RULES-1:0][ADDR_WIDTH-1:0] END_ADDR =
        {64'h0, 64'h8100_0000, 64'h1A00_2000},
    parameter int IDX_WIDTH  = $clog2(NR_RULES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    // Configuration port
    input  logic                  cfg_we_i,
    input  logic [IDX_WIDTH-1:0]  cfg_idx_i,
    input  logic                  cfg_sel_i,
    input  logic [ADDR_WIDTH-1:0] cfg_data_i,
    input  logic                  cfg_lock_i,
    output logic                  cfg_err_o,
    output logic                  cfg_locked_o,

    // Lookup request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,

    // Lookup response
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDX_WIDTH-1:0]  rsp_idx_o,
    output logic                  rsp_miss_o,

    // Statistics
    output logic [31:0]           miss_cnt_o
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_start [NR_RULES];
    logic [ADDR_WIDTH-1:0] r_end   [NR_RULES];
    logic                  r_locked;
    logic                  r_cfg_err;
    logic                  r_rsp_valid;
    logic [IDX_WIDTH-1:0]  r_rsp_idx;
    logic                  r_rsp_miss;
    logic [31:0]           r_miss_cnt;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic                  w_idx_in_range;
    logic                  w_write_ok;
    logic                  w_accept;
    logic [NR_RULES-1:0]   w_hit;
    logic [IDX_WIDTH-1:0]  w_dec_idx;
    logic                  w_dec_miss;
    logic                  w_cnt_sat;

    // -----------------------------------------------------------------------
    // Configuration qualification
    //
    // A write is honoured only while the table is unlocked and the index
    // names a real rule. The lock register is sampled before the edge, so a
    // write that arrives together with cfg_lock_i still lands; the lock then
    // takes effect from the following cycle.
    // -----------------------------------------------------------------------
    assign w_idx_in_range = (cfg_idx_i < IDX_WIDTH'(NR_RULES));
    assign w_write_ok     = cfg_we_i && !r_locked && w_idx_in_range;

    // -----------------------------------------------------------------------
    // Handshake
    //
    // The single output slot can take a new result when it is empty or when
    // it is being drained in this same cycle. Because of this there is no
    // bubble between back-to-back lookups.
    // -----------------------------------------------------------------------
    assign req_ready_o = !r_rsp_valid || rsp_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;

    // -----------------------------------------------------------------------
    // Per-rule window match
    //
    // A rule whose end address is less than or equal to its start address
    // describes an empty window. The explicit end > start term keeps the
    // intent obvious and guarantees that such a rule never hits.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NR_RULES; g++) begin : g_rule_match
        assign w_hit[g] = (r_end[g] > r_start[g])
                       && (req_addr_i >= r_start[g])
                       && (req_addr_i <  r_end[g]);
    end

    // -----------------------------------------------------------------------
    // Priority select
    //
    // The loop walks from the highest index down to the lowest, so the
    // lowest matching rule is written last and wins an overlap. When no
    // rule matches, the defaults point the lookup at the error slave.
    // -----------------------------------------------------------------------
    always_comb begin
        w_dec_idx  = IDX_WIDTH'(NR_RULES);
        w_dec_miss = 1'b1;
        for (int i = NR_RULES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_dec_idx  = IDX_WIDTH'(i);
                w_dec_miss = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Address table
    //
    // Lookups in the same cycle decode against the pre-edge contents. A
    // write therefore affects only requests accepted from the next cycle
    // onward, and it never changes a result that is already registered.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_RULES; i++) begin
                r_start[i] <= START_ADDR[i];
                r_end[i]   <= END_ADDR[i];
            end
        end else begin
            for (int i = 0; i < NR_RULES; i++) begin
                if (w_write_ok && (cfg_idx_i == IDX_WIDTH'(i))) begin
                    if (cfg_sel_i) begin
                        r_end[i]   <= cfg_data_i;
                    end else begin
                        r_start[i] <= cfg_data_i;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock and error reporting
    //
    // Once the lock is set it stays set until reset. The error flag is a
    // one-cycle pulse that follows any rejected write strobe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_locked  <= r_locked || cfg_lock_i;
            r_cfg_err <= cfg_we_i && !w_write_ok;
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    //
    // On an accept, the register loads a fresh decode. If the consumer takes
    // the result and nothing new arrives, the slot empties. In every other
    // case (including back-pressure), the held result stays untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= '0;
            r_rsp_miss  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_idx   <= w_dec_idx;
            r_rsp_miss  <= w_dec_miss;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Miss counter
    //
    // The counter counts accepted lookups that miss. It sticks at all-ones
    // rather than wrapping, so that a large count is never mistaken for a
    // small one.
    // -----------------------------------------------------------------------
    assign w_cnt_sat = &r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_cnt <= '0;
        end else if (w_accept && w_dec_miss && !w_cnt_sat) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cfg_err_o    = r_cfg_err;
    assign cfg_locked_o = r_locked;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_idx_o    = r_rsp_idx;
    assign rsp_miss_o   = r_rsp_miss;
    assign miss_cnt_o   = r_miss_cnt;

endmodule

// File: tb/tb_kerbin_addr_decoder.sv
// ---------------------------------------------------------------------------
// tb_kerbin_addr_decoder
//
// Directed, table-driven bench for kerbin_addr_decoder with the default
// parameters. The default rule set is:
//   rule0 = [0x1A00_0000, 0x1A00_2000)
//   rule1 = [0x8000_0000, 0x8100_0000)
//   rule2 = [0, 0), which is disabled
// ---------------------------------------------------------------------------
module tb_kerbin_addr_decoder;

    localparam int AW = 64;
    localparam int IW = 2;

    logic          clk;
    logic          rstN;
    logic          cfgWe;
    logic [IW-1:0] cfgIdx;
    logic          cfgSel;
    logic [AW-1:0] cfgData;
    logic          cfgLock;
    logic          cfgErr;
    logic          cfgLocked;
    logic          reqValid;
    logic          reqReady;
    logic [AW-1:0] reqAddr;
    logic          rspValid;
    logic          rspReady;
    logic [IW-1:0] rspIdx;
    logic          rspMiss;
    logic [31:0]   missCnt;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] expIdx;
        logic          expMiss;
    } vec_t;

    vec_t vecs[8];

    kerbin_addr_decoder dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .cfg_we_i     (cfgWe),
        .cfg_idx_i    (cfgIdx),
        .cfg_sel_i    (cfgSel),
        .cfg_data_i   (cfgData),
        .cfg_lock_i   (cfgLock),
        .cfg_err_o    (cfgErr),
        .cfg_locked_o (cfgLocked),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_addr_i   (reqAddr),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_idx_o    (rspIdx),
        .rsp_miss_o   (rspMiss),
        .miss_cnt_o   (missCnt)
    );

    // Free-running clock with a 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its required value
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One accepted lookup with rsp_ready high; checks the registered result
    task automatic applyStimulus(input logic [AW-1:0] addr,
                                 input logic [IW-1:0] expIdx,
                                 input logic expMiss, input string name);
        @(negedge clk);
        reqValid = 1'b1;
        reqAddr  = addr;
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        checkOutput({name, ".valid"}, 64'(rspValid), 64'd1);
        checkOutput({name, ".idx"},   64'(rspIdx),   64'(expIdx));
        checkOutput({name, ".miss"},  64'(rspMiss),  64'(expMiss));
    endtask

    // One config write cycle; checks the error pulse that follows it
    task automatic cfgWrite(input logic [IW-1:0] idx, input logic sel,
                            input logic [AW-1:0] data, input logic lock,
                            input logic expErr, input string name);
        @(negedge clk);
        cfgWe   = 1'b1;
        cfgIdx  = idx;
        cfgSel  = sel;
        cfgData = data;
        cfgLock = lock;
        @(posedge clk);
        #1;
        cfgWe   = 1'b0;
        cfgLock = 1'b0;
        checkOutput({name, ".err"}, 64'(cfgErr), 64'(expErr));
    endtask

    // Idle cycle that drains any pending response
    task automatic idleCycle();
        @(negedge clk);
        reqValid = 1'b0;
        rspReady = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{64'h1A00_0010, 2'd0, 1'b0};
        vecs[1] = '{64'h8000_0000, 2'd1, 1'b0};
        vecs[2] = '{64'h80FF_FFFF, 2'd1, 1'b0};
        vecs[3] = '{64'h8100_0000, 2'd3, 1'b1};
        vecs[4] = '{64'h1A00_2000, 2'd3, 1'b1};
        vecs[5] = '{64'h1A00_0000, 2'd0, 1'b0};
        vecs[6] = '{64'h19FF_FFFF, 2'd3, 1'b1};
        vecs[7] = '{64'h0000_0000, 2'd3, 1'b1};

        rstN     = 1'b0;
        cfgWe    = 1'b0;
        cfgIdx   = '0;
        cfgSel   = 1'b0;
        cfgData  = '0;
        cfgLock  = 1'b0;
        reqValid = 1'b0;
        reqAddr  = '0;
        rspReady = 1'b1;

        // Reset state
        #12;
        checkOutput("rst.valid",  64'(rspValid),  64'd0);
        checkOutput("rst.idx",    64'(rspIdx),    64'd0);
        checkOutput("rst.miss",   64'(rspMiss),   64'd0);
        checkOutput("rst.cnt",    64'(missCnt),   64'd0);
        checkOutput("rst.locked", 64'(cfgLocked), 64'd0);
        checkOutput("rst.err",    64'(cfgErr),    64'd0);
        checkOutput("rst.ready",  64'(reqReady),  64'd1);
        @(negedge clk);
        rstN = 1'b1;

        // Default table, back-to-back lookups
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].expIdx, vecs[i].expMiss,
                          $sformatf("vec%0d", i));
        end
        checkOutput("vec.cnt", 64'(missCnt), 64'd4);

        // Back-pressure: A accepted, then B stalls for 3 cycles
        idleCycle();
        @(negedge clk);
        reqValid = 1'b1;
        reqAddr  = 64'h1A00_0010;
        rspReady = 1'b0;
        #1;
        checkOutput("bp.readyEmpty", 64'(reqReady), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            reqAddr = 64'h8000_0000;
            #1;
            checkOutput($sformatf("bp.ready%0d", k), 64'(reqReady), 64'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp.holdV%0d", k), 64'(rspValid), 64'd1);
            checkOutput($sformatf("bp.holdI%0d", k), 64'(rspIdx),   64'd0);
        end
        // Drain: each edge consumes the result present just before it
        @(negedge clk);
        rspReady = 1'b1;
        reqAddr  = 64'h8000_0000;
        #1;
        checkOutput("bp.outA", 64'(rspIdx), 64'd0);
        @(negedge clk);
        reqAddr = 64'h8100_0000;
        #1;
        checkOutput("bp.outB", 64'(rspIdx), 64'd1);
        @(negedge clk);
        reqAddr = 64'h80FF_FFFF;
        #1;
        checkOutput("bp.outC",  64'(rspIdx),  64'd3);
        checkOutput("bp.missC", 64'(rspMiss), 64'd1);
        @(negedge clk);
        reqValid = 1'b0;
        #1;
        checkOutput("bp.outD",  64'(rspIdx),   64'd1);
        checkOutput("bp.validD", 64'(rspValid), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("bp.empty", 64'(rspValid), 64'd0);
        checkOutput("bp.cnt",   64'(missCnt),  64'd5);

        // Reprogram rule2 and reject an out-of-range index
        cfgWrite(2'd2, 1'b0, 64'h4000_0000, 1'b0, 1'b0, "cfg.s2");
        cfgWrite(2'd2, 1'b1, 64'h5000_0000, 1'b0, 1'b0, "cfg.e2");
        applyStimulus(64'h4000_0000, 2'd2, 1'b0, "cfg.lo");
        applyStimulus(64'h4FFF_FFFF, 2'd2, 1'b0, "cfg.hi");
        applyStimulus(64'h5000_0000, 2'd3, 1'b1, "cfg.end");
        cfgWrite(2'd3, 1'b0, 64'h0, 1'b0, 1'b1, "cfg.badIdx");
        idleCycle();
        checkOutput("cfg.errPulse", 64'(cfgErr), 64'd0);

        // Overlap (lowest wins) and disabled rule
        cfgWrite(2'd2, 1'b0, 64'h8000_0000, 1'b0, 1'b0, "ov.s2");
        cfgWrite(2'd2, 1'b1, 64'h9000_0000, 1'b0, 1'b0, "ov.e2");
        applyStimulus(64'h8000_0100, 2'd1, 1'b0, "ov.low");
        applyStimulus(64'h8100_0000, 2'd2, 1'b0, "ov.r2");
        cfgWrite(2'd2, 1'b1, 64'h8000_0000, 1'b0, 1'b0, "ov.dis");
        applyStimulus(64'h8100_0000, 2'd3, 1'b1, "ov.miss");

        // Write and lookup in the same cycle: the lookup sees the old table
        @(negedge clk);
        cfgWe    = 1'b1;
        cfgIdx   = 2'd0;
        cfgSel   = 1'b0;
        cfgData  = 64'h2000_0000;
        reqValid = 1'b1;
        reqAddr  = 64'h1A00_0000;
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        cfgWe    = 1'b0;
        reqValid = 1'b0;
        checkOutput("same.idx",  64'(rspIdx),  64'd0);
        checkOutput("same.miss", 64'(rspMiss), 64'd0);
        applyStimulus(64'h1A00_0000, 2'd3, 1'b1, "same.next");
        checkOutput("same.cnt", 64'(missCnt), 64'd8);

        // Write together with lock: the write lands, then the lock holds
        cfgWrite(2'd0, 1'b0, 64'h1000_0000, 1'b1, 1'b0, "lock.wr");
        checkOutput("lock.set", 64'(cfgLocked), 64'd1);
        applyStimulus(64'h1000_0000, 2'd0, 1'b0, "lock.applied");
        cfgWrite(2'd2, 1'b0, 64'h0, 1'b0, 1'b1, "lock.rej");
        applyStimulus(64'h0000_1000, 2'd3, 1'b1, "lock.unchg");
        checkOutput("lock.hold", 64'(cfgLocked), 64'd1);

        // Saturation of the miss counter
        idleCycle();
        @(negedge clk);
        force dut.r_miss_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_miss_cnt;
        #1;
        checkOutput("sat.preset", 64'(missCnt), 64'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(64'h0000_1000, 2'd3, 1'b1, $sformatf("sat.m%0d", k));
            checkOutput($sformatf("sat.cnt%0d", k), 64'(missCnt),
                        64'hFFFF_FFFF);
        end

        // Asynchronous reset with a result in flight
        @(negedge clk);
        reqValid = 1'b1;
        reqAddr  = 64'h8000_0000;
        rspReady = 1'b0;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        checkOutput("arst.pre", 64'(rspValid), 64'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst.valid",  64'(rspValid),  64'd0);
        checkOutput("arst.idx",    64'(rspIdx),    64'd0);
        checkOutput("arst.miss",   64'(rspMiss),   64'd0);
        checkOutput("arst.cnt",    64'(missCnt),   64'd0);
        checkOutput("arst.locked", 64'(cfgLocked), 64'd0);
        checkOutput("arst.err",    64'(cfgErr),    64'd0);
        @(negedge clk);
        rstN     = 1'b1;
        rspReady = 1'b1;
        applyStimulus(64'h1000_0000, 2'd3, 1'b1, "arst.tbl");
        applyStimulus(64'h1A00_0010, 2'd0, 1'b0, "arst.r0");
        cfgWrite(2'd1, 1'b1, 64'h8200_0000, 1'b0, 1'b0, "arst.unlock");
        applyStimulus(64'h8180_0000, 2'd1, 1'b0, "arst.wr");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
